// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, drives the req/gnt/rvalid instruction bus and feeds if_id.
// Optional feature: define IF_MISALIGN_CHK_EN to add the registered misalign_o jump-target flag.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter logic [2:0]  HOLD_IF  = 3'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic [2:0]  hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic        misalign_o
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        kill_q, kill_d;
    logic [31:0] buf_q, buf_d;

    logic        hold;
    logic        reqOut;
    logic [31:0] jumpPc;
    logic [31:0] nextPc;

    assign hold   = (hold_flag_i >= HOLD_IF);
    assign jumpPc = jump_addr_i & ~32'h3;
    assign nextPc = req_pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            kill_q   <= 1'b0;
            buf_q    <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            kill_q   <= kill_d;
            buf_q    <= buf_d;
        end
    end

    // A jump overrides hold and any response; a dropped response always returns to REQ.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        kill_d       = kill_q;
        buf_d        = buf_q;
        reqOut       = 1'b0;
        ibus_addr_o  = pc_q;
        inst_o       = NOP_INST;
        inst_addr_o  = pc_q;
        inst_valid_o = 1'b0;

        case (state_q)
            S_REQ: begin
                reqOut = ~hold & ~jump_flag_i;
                if (jump_flag_i) begin
                    pc_d = jumpPc;
                end else if (reqOut && ibus_gnt_i) begin
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (jump_flag_i) begin
                    pc_d = jumpPc;
                    if (ibus_rvalid_i) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (ibus_rvalid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (!hold) begin
                        inst_o       = ibus_rdata_i;
                        inst_addr_o  = req_pc_q;
                        inst_valid_o = 1'b1;
                        pc_d         = nextPc;
                        state_d      = S_REQ;
                    end else begin
                        buf_d   = ibus_rdata_i;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (jump_flag_i) begin
                    pc_d    = jumpPc;
                    state_d = S_REQ;
                end else if (!hold) begin
                    inst_o       = buf_q;
                    inst_addr_o  = req_pc_q;
                    inst_valid_o = 1'b1;
                    pc_d         = nextPc;
                    state_d      = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        ibus_req_o = reqOut;

        // Outputs read as idle while reset is held, even though REQ would otherwise request.
        if (!rst) begin
            ibus_req_o   = 1'b0;
            ibus_addr_o  = 32'h0;
            inst_o       = NOP_INST;
            inst_addr_o  = RESET_PC;
            inst_valid_o = 1'b0;
        end
    end

`ifdef IF_MISALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= jump_flag_i & (|jump_addr_i[1:0]);
        end
    end

    assign misalign_o = misalign_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: bus slave model, queue-based scoreboard of the expected instruction
// stream, directed scenarios followed by randomized jumps/holds/latencies.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [2:0]  HOLD_IF  = 3'd2;

    logic        clk;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic [2:0]  hold_flag_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
`ifdef IF_MISALIGN_CHK_EN
    logic        misalign_o;
`endif

    if_fetch #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST),
        .HOLD_IF (HOLD_IF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .hold_flag_i  (hold_flag_i),
        .ibus_req_o   (ibus_req_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_gnt_i   (ibus_gnt_i),
        .ibus_rvalid_i(ibus_rvalid_i),
        .ibus_rdata_i (ibus_rdata_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
`ifdef IF_MISALIGN_CHK_EN
        ,
        .misalign_o   (misalign_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] expQ[$];
    bit          pending;
    logic [31:0] pendAddr;
    int          pendDelay;
    bit          gntAlways;
    int          maxDelay;
    int          fixedDelay;
    bit          strayEn;
    bit          jumpNow, holdNow, curMis, lastMis;
    int          validCount = 0;
    int          idleCycles = 0;
    logic [31:0] monExp;

    // Memory contents: a fixed scramble of the address, so address 0 holds 32'hDEADBEEF.
    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    // Expected stream restarts at a given address: sequential words from there on.
    task automatic restartStream(input logic [31:0] startAddr);
        expQ.delete();
        for (int k = 0; k < 8; k++) expQ.push_back(startAddr + 32'(4 * k));
    endtask

    task automatic resetModel();
        restartStream(RESET_PC);
        pending = 1'b0;
        lastMis = 1'b0;
        curMis  = 1'b0;
        jumpNow = 1'b0;
        holdNow = 1'b0;
        idleCycles = 0;
    endtask

    // One clock of stimulus, applied just after the rising edge; also plays the bus slave.
    task automatic applyStimulus(input bit jump, input logic [31:0] jaddr, input logic [2:0] hold);
        @(posedge clk);
        #1;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = $urandom;
        if (pending) begin
            if (pendDelay == 0) begin
                ibus_rvalid_i = 1'b1;
                ibus_rdata_i  = memData(pendAddr);
                pending       = 1'b0;
            end else begin
                pendDelay--;
            end
        end else if (strayEn && $urandom_range(0, 9) == 0) begin
            ibus_rvalid_i = 1'b1;
        end
        ibus_gnt_i  = gntAlways ? 1'b1 : ($urandom_range(0, 2) != 0);
        jump_flag_i = jump;
        jump_addr_i = jaddr;
        hold_flag_i = hold;
        jumpNow     = jump;
        holdNow     = (hold >= HOLD_IF);
        curMis      = jump && (jaddr[1:0] != 2'b00);
        if (jump) restartStream(jaddr & ~32'h3);
    endtask

    task automatic waitForGrant();
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            applyStimulus(1'b0, 32'h0, 3'd0);
            #1;
            if (ibus_req_o && ibus_gnt_i) got = 1'b1;
        end
        if (!got) checkOutput("grantTimeout", 32'(got), 32'd1);
    endtask

    task automatic applyReset();
        applyStimulus(1'b0, 32'h0, 3'd0);
        rst = 1'b0;
        resetModel();
        repeat (2) applyStimulus(1'b0, 32'h0, 3'd0);
        applyStimulus(1'b0, 32'h0, 3'd0);
        rst = 1'b1;
    endtask

    // Slave address phase: capture each granted request and choose its response latency.
    always @(negedge clk) begin
        if (rst && ibus_req_o && ibus_gnt_i) begin
            checkOutput("singleOutstanding", 32'(pending), 32'd0);
            pending   = 1'b1;
            pendAddr  = ibus_addr_o;
            pendDelay = (fixedDelay >= 0) ? fixedDelay : $urandom_range(0, maxDelay);
        end
    end

    // Scoreboard monitor: pops the expected stream whenever an instruction is presented.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("rstReq", 32'(ibus_req_o), 32'd0);
            checkOutput("rstAddr", ibus_addr_o, 32'h0);
            checkOutput("rstValid", 32'(inst_valid_o), 32'd0);
            checkOutput("rstInst", inst_o, NOP_INST);
            checkOutput("rstInstAddr", inst_addr_o, RESET_PC);
`ifdef IF_MISALIGN_CHK_EN
            checkOutput("rstMisalign", 32'(misalign_o), 32'd0);
`endif
            lastMis    = 1'b0;
            idleCycles = 0;
        end else begin
`ifdef IF_MISALIGN_CHK_EN
            checkOutput("misalign", 32'(misalign_o), 32'(lastMis));
`endif
            lastMis = curMis;
            if (jumpNow || holdNow) checkOutput("stallNoValid", 32'(inst_valid_o), 32'd0);
            if (jumpNow) idleCycles = 0;
            if (inst_valid_o) begin
                validCount++;
                idleCycles = 0;
                if (expQ.size() == 0) begin
                    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd1);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("instAddr", inst_addr_o, monExp);
                    checkOutput("instData", inst_o, memData(monExp));
                    if (expQ.size() == 0) expQ.push_back(monExp + 32'd4);
                    while (expQ.size() < 8) expQ.push_back(expQ[$] + 32'd4);
                end
            end else begin
                checkOutput("nopWhenIdle", inst_o, NOP_INST);
                if (!holdNow && !jumpNow) idleCycles++;
                if (idleCycles > 40) begin
                    checkOutput("fetchProgress", 32'(idleCycles), 32'd0);
                    idleCycles = 0;
                end
            end
            if (ibus_req_o) begin
                checkOutput("reqAddr", ibus_addr_o, expQ[0]);
                checkOutput("reqGating", {30'h0, jumpNow, holdNow}, 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL globalTimeout: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int v0;
        logic [31:0] tgt;
        logic [2:0]  hv;
        bit          jv;

        rst = 1'b0;
        jump_flag_i = 1'b0; jump_addr_i = 32'h0; hold_flag_i = 3'd0;
        ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'h0;
        gntAlways = 1'b1; maxDelay = 0; fixedDelay = 0; strayEn = 1'b0;
        resetModel();

        // Reset release with zero-wait memory: one instruction every second cycle.
        repeat (3) applyStimulus(1'b0, 32'h0, 3'd0);
        applyStimulus(1'b0, 32'h0, 3'd0);
        rst = 1'b1;
        v0 = validCount;
        repeat (20) applyStimulus(1'b0, 32'h0, 3'd0);
        checkOutput("zeroWaitRate", 32'(validCount - v0), 32'd10);

        // Hold during WAIT: the buffered word is presented when hold drops.
        applyReset();
        applyStimulus(1'b0, 32'h0, 3'd2);
        applyStimulus(1'b0, 32'h0, 3'd3);
        applyStimulus(1'b0, 32'h0, 3'd7);
        applyStimulus(1'b0, 32'h0, 3'd1);
        #1;
        checkOutput("holdReleaseValid", 32'(inst_valid_o), 32'd1);
        checkOutput("holdReleaseData", inst_o, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h0, 3'd0);
        #1;
        checkOutput("holdNextReq", {ibus_addr_o[31:1], ibus_req_o}, {31'h2, 1'b1});

        // Jump while waiting, response three cycles late: stale word dropped.
        fixedDelay = 3;
        waitForGrant();
        applyStimulus(1'b1, 32'h100, 3'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 32'h0, 3'd0);
            #1;
            if (ibus_rvalid_i) checkOutput("staleDrop", 32'(inst_valid_o), 32'd0);
            if (ibus_req_o) break;
        end
        checkOutput("jumpWaitReq", ibus_addr_o, 32'h100);

        // Jump in the same cycle as rvalid.
        fixedDelay = 1;
        waitForGrant();
        applyStimulus(1'b0, 32'h0, 3'd0);
        applyStimulus(1'b1, 32'h200, 3'd0);
        #1;
        checkOutput("jumpRvalidSetup", 32'(ibus_rvalid_i), 32'd1);
        checkOutput("jumpRvalidDrop", 32'(inst_valid_o), 32'd0);
        applyStimulus(1'b0, 32'h0, 3'd0);
        #1;
        checkOutput("jumpRvalidReq", {ibus_addr_o, 31'h0, ibus_req_o}, {32'h200, 32'h1});

        // Misaligned jump target is aligned; flag pulses only when the check is built.
        fixedDelay = 0;
        waitForGrant();
        applyStimulus(1'b1, 32'h302, 3'd0);
        applyStimulus(1'b0, 32'h0, 3'd0);
        #1;
        checkOutput("misalignReq", {ibus_addr_o, 31'h0, ibus_req_o}, {32'h300, 32'h1});
`ifdef IF_MISALIGN_CHK_EN
        checkOutput("misalignPulse", 32'(misalign_o), 32'd1);
        applyStimulus(1'b0, 32'h0, 3'd0);
        #1;
        checkOutput("misalignClear", 32'(misalign_o), 32'd0);
`endif

        // PC wrap at the top of the address space.
        waitForGrant();
        applyStimulus(1'b1, 32'hFFFF_FFFC, 3'd0);
        applyStimulus(1'b0, 32'h0, 3'd0);
        #1;
        checkOutput("wrapReqTop", {ibus_addr_o, 31'h0, ibus_req_o}, {32'hFFFF_FFFC, 32'h1});
        applyStimulus(1'b0, 32'h0, 3'd0);
        #1;
        checkOutput("wrapDeliver", {inst_addr_o, 31'h0, inst_valid_o}, {32'hFFFF_FFFC, 32'h1});
        applyStimulus(1'b0, 32'h0, 3'd0);
        #1;
        checkOutput("wrapReqZero", {ibus_addr_o, 31'h0, ibus_req_o}, {32'h0, 32'h1});

        // Reset asserted while a request is outstanding.
        fixedDelay = 2;
        waitForGrant();
        applyStimulus(1'b0, 32'h0, 3'd0);
        #1;
        rst = 1'b0;
        resetModel();
        #1;
        checkOutput("midRstReq", 32'(ibus_req_o), 32'd0);
        checkOutput("midRstValid", 32'(inst_valid_o), 32'd0);
        checkOutput("midRstInst", inst_o, NOP_INST);
        checkOutput("midRstInstAddr", inst_addr_o, RESET_PC);
        repeat (2) applyStimulus(1'b0, 32'h0, 3'd0);
        rst = 1'b1;

        // Randomized traffic: grant gaps, latencies, holds, jumps, stray responses.
        gntAlways = 1'b0; maxDelay = 3; fixedDelay = -1; strayEn = 1'b1;
        v0 = validCount;
        repeat (3000) begin
            jv = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else tgt = $urandom & 32'h0000_0FFF;
            hv = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
            applyStimulus(jv, tgt, hv);
        end
        strayEn = 1'b0;
        repeat (10) applyStimulus(1'b0, 32'h0, 3'd0);
        checkOutput("randomLiveness", 32'(validCount - v0 >= 300), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
